ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of mapped keys, legal range 1-8.
REQ-002 Parameter KEY_CODES, default {8'h1D,8'h23,8'h1B,8'h1C}: NUM_KEYS x 8-bit scan codes; key i is bits [8i+7:8i].
REQ-003 Parameter KEY_EXT, default 0: NUM_KEYS-bit mask; bit i set means key i requires the E0 prefix.
REQ-004 Parameter TIMEOUT_CYCLES, default 100000: clk cycles allowed between PS/2 falling edges inside a frame.
REQ-005 clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 PS2_CLK  input  1  raw PS/2 clock, asynchronous to clk.
REQ-008 PS2_DATA  input  1  raw PS/2 data, asynchronous to clk.
REQ-009 keys_held  output  NUM_KEYS  level; bit i is high while key i is down.
REQ-010 keys_press  output  NUM_KEYS  one-cycle pulse on a key-i up-to-down transition.
REQ-011 keys_release  output  NUM_KEYS  one-cycle pulse on a key-i down-to-up transition.
REQ-012 code_valid  output  1  one-cycle strobe; a complete non-prefix code is on code_data.
REQ-013 code_data  output  8  last non-prefix scan code.
REQ-014 code_break  output  1  F0 preceded code_data.
REQ-015 code_ext  output  1  E0 preceded code_data.
REQ-016 frame_err  output  1  one-cycle pulse on a dropped frame.

Function
REQ-017 PS2_CLK and PS2_DATA SHALL each pass through a 2-flop synchroniser; a falling edge is detected from the synchronised clock and its delayed copy.
REQ-018 Receiver FSM states SHALL be IDLE and RX.
- IDLE -> RX on an edge with data=0 (start bit).
- An edge with data=1 in IDLE is ignored.
REQ-019 In RX, the 4-bit bit counter SHALL shift data bits 1-8 LSB first, capture bit 9 as parity and bit 10 as stop, then return to IDLE.
REQ-020 A stop bit of 0 SHALL drop the frame and pulse frame_err.
REQ-021 In RX, if TIMEOUT_CYCLES clk cycles pass with no falling edge, the FSM SHALL return to IDLE, discard partial data and pulse frame_err; the watchdog counter reloads on every edge.
REQ-022 For an accepted byte: E0 sets the pending-ext flag; F0 sets the pending-break flag; neither strobes code_valid.
REQ-023 Any other accepted byte SHALL:
- load code_data, code_break and code_ext from the flags;
- pulse code_valid one clk cycle after the stop-bit edge is detected;
- clear both flags.
REQ-024 Key i matches when code_data==KEY_CODES[i] and code_ext==KEY_EXT[i]. With code_valid on a match:
- make sets keys_held[i];
- break clears it.
keys_press/keys_release SHALL pulse in the same cycle as code_valid, and only when held actually changes (typematic repeats give no pulse).
REQ-025 Duplicate entries in KEY_CODES SHALL all update together.
REQ-026 A dropped frame SHALL leave the pending flags unchanged.

Reset
REQ-027 While rst_n=0:
- all outputs are 0;
- FSM is IDLE; counters and flags clear;
- synchroniser flops are 1 (bus idle).
REQ-028 Deasserting rst_n mid-frame SHALL resume in IDLE; the partial frame is lost and frame_err is not pulsed.

Configuration
REQ-029 Macro PS2_PARITY_CHECK_EN.
- Defined: a frame with even parity over data+parity bits is dropped and frame_err pulsed.
- Undefined: the parity bit is captured and ignored.

Verification
REQ-030 Frame 1C, then F0,1C, defaults -> keys_held[0] rises and keys_press=4'b0001 for 1 cycle; after the break, keys_held=0 and keys_release=4'b0001.
REQ-031 1D sent three times -> one keys_press pulse (4'b1000), three code_valid strobes, keys_held[3] stays 1.
REQ-032 E0,75 with KEY_CODES[0]=75, KEY_EXT[0]=1 -> code_ext=1, keys_held[0]=1; plain 75 -> code_valid with code_ext=0, no key change.
REQ-033 Frame 23 with flipped parity -> with PS2_PARITY_CHECK_EN, frame_err pulse and no code_valid; without it, code_valid with code_data=23.
REQ-034 PS2_CLK stopped after 5 bits, TIMEOUT_CYCLES=50 -> frame_err on cycle 50 after the last edge; a following valid 1B frame decodes correctly.
REQ-035 rst_n pulsed low mid-frame while keys_held=4'b0100 -> all outputs 0; the next full frame decodes normally.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver with scan-code decode and a small table of
// tracked keys. Frames are synchronised, shifted in LSB first and guarded
// by an inter-edge watchdog. E0/F0 prefixes are folded into flags that
// qualify the next code.
// Optional build macro: PS2_PARITY_CHECK_EN -- when defined, frames with
// bad (even) parity are dropped with frame_err; otherwise parity is ignored.

// Per-key tracker: holds the down state of one mapped key and pulses on
// real transitions only, so typematic repeats stay silent.
module ps2_key_slot #(
  parameter logic [7:0] CODE = 8'h00,
  parameter logic       EXT  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_upd,
  input  logic [7:0] i_code,
  input  logic       i_ext,
  input  logic       i_brk,
  output logic       o_held,
  output logic       o_press,
  output logic       o_release
);
  logic w_hit;
  logic r_held, r_press, r_release;

  assign w_hit = i_upd && (i_code == CODE) && (i_ext == EXT);

  // Update held level and derive make/break pulses from the old level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held    <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (w_hit) begin
        r_held    <= !i_brk;
        r_press   <= !i_brk && !r_held;
        r_release <= i_brk && r_held;
      end
    end
  end

  assign o_held    = r_held;
  assign o_press   = r_press;
  assign o_release = r_release;
endmodule

module ps2_key_decoder #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h1D, 8'h23, 8'h1B, 8'h1C},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = '0,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                PS2_CLK,
  input  logic                PS2_DATA,
  output logic [NUM_KEYS-1:0] keys_held,
  output logic [NUM_KEYS-1:0] keys_press,
  output logic [NUM_KEYS-1:0] keys_release,
  output logic                code_valid,
  output logic [7:0]          code_data,
  output logic                code_break,
  output logic                code_ext,
  output logic                frame_err
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RX   = 1'b1;
  localparam int         WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      r_clk_sync, r_dat_sync;
  logic            r_clk_dly;
  logic [0:0]      r_state;
  logic [3:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [WD_W-1:0] r_wdog;
  logic            r_frame_err;
  logic            r_ext_pend, r_brk_pend;
  logic            r_code_valid, r_code_break, r_code_ext;
  logic [7:0]      r_code_data;

  logic w_fall, w_bit, w_stop_edge, w_par_ok, w_frame_ok, w_accept;
  logic w_prefix, w_upd, w_timeout;

  // Bring the asynchronous bus into the clk domain; idle bus reads as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_dly  <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[0], PS2_DATA};
      r_clk_dly  <= r_clk_sync[1];
    end
  end

  assign w_fall = r_clk_dly & ~r_clk_sync[1];
  assign w_bit  = r_dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ^{r_shift, r_parity};
`else
  assign w_par_ok = 1'b1;
`endif

  // bitcnt 0-7 are data, 8 is parity, 9 is stop.
  assign w_stop_edge = (r_state == S_RX) && w_fall && (r_bitcnt == 4'd9);
  assign w_frame_ok  = w_bit && w_par_ok;
  assign w_accept    = w_stop_edge && w_frame_ok;
  assign w_prefix    = (r_shift == 8'hE0) || (r_shift == 8'hF0);
  assign w_upd       = w_accept && !w_prefix;
  assign w_timeout   = (r_state == S_RX) && !w_fall && (r_wdog == WD_LAST);

  // Frame receiver: start detect, shift, parity/stop capture, watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 4'd0;
      r_shift     <= 8'd0;
      r_parity    <= 1'b0;
      r_wdog      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wdog   <= '0;
          r_bitcnt <= 4'd0;
          r_shift  <= 8'd0;
          if (w_fall && !w_bit) r_state <= S_RX;
        end
        S_RX: begin
          if (w_fall) begin
            r_wdog   <= '0;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt < 4'd8) begin
              r_shift <= {w_bit, r_shift[7:1]};
            end else if (r_bitcnt == 4'd8) begin
              r_parity <= w_bit;
            end else begin
              r_state     <= S_IDLE;
              r_frame_err <= !w_frame_ok;
            end
          end else if (w_timeout) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Prefix flags and the registered code strobe; dropped frames never reach here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_code_valid <= 1'b0;
      r_code_data  <= 8'd0;
      r_code_break <= 1'b0;
      r_code_ext   <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      if (w_accept) begin
        if (r_shift == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_code_data  <= r_shift;
          r_code_break <= r_brk_pend;
          r_code_ext   <= r_ext_pend;
          r_code_valid <= 1'b1;
          r_ext_pend   <= 1'b0;
          r_brk_pend   <= 1'b0;
        end
      end
    end
  end

  // One tracker per mapped key; duplicate codes simply hit several slots.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    ps2_key_slot #(
      .CODE (KEY_CODES[8*g +: 8]),
      .EXT  (KEY_EXT[g])
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_upd     (w_upd),
      .i_code    (r_shift),
      .i_ext     (r_ext_pend),
      .i_brk     (r_brk_pend),
      .o_held    (keys_held[g]),
      .o_press   (keys_press[g]),
      .o_release (keys_release[g])
    );
  end

  assign code_valid = r_code_valid;
  assign code_data  = r_code_data;
  assign code_break = r_code_break;
  assign code_ext   = r_code_ext;
  assign frame_err  = r_frame_err;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scenarios plus random
// frames. A reference model predicts every code/error event into a queue;
// a monitor pops and compares whenever the DUT strobes.
module tb_ps2_key_decoder;
  localparam int NK = 6;
  // key0=1C key1=1B key2=23 key3=1D key4=E0+75 key5=1C (duplicate of key0)
  localparam logic [NK*8-1:0] KC = {8'h1C, 8'h75, 8'h1D, 8'h23, 8'h1B, 8'h1C};
  localparam logic [NK-1:0]   KE = 6'b010000;
  localparam int TO = 50;
  localparam int H  = 12;

  logic clk, rst_n, PS2_CLK, PS2_DATA;
  logic [NK-1:0] keys_held, keys_press, keys_release;
  logic code_valid, code_break, code_ext, frame_err;
  logic [7:0] code_data;

  ps2_key_decoder #(
    .NUM_KEYS(NK), .KEY_CODES(KC), .KEY_EXT(KE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .keys_held(keys_held), .keys_press(keys_press), .keys_release(keys_release),
    .code_valid(code_valid), .code_data(code_data), .code_break(code_break),
    .code_ext(code_ext), .frame_err(frame_err)
  );

  typedef struct {
    bit            is_err;
    logic [7:0]    data;
    bit            brk;
    bit            ext;
    logic [NK-1:0] held;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    int            tmin;
    int            tmax;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_err = 0, cyc = 0, last_fall = 0;

  logic [7:0] m_code[NK] = '{8'h1C, 8'h1B, 8'h23, 8'h1D, 8'h75, 8'h1C};
  bit         m_kext[NK] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [NK-1:0] m_held = '0;
  bit m_ext = 0, m_brk = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DATA = b;
    tick(H);
    PS2_CLK = 1'b0;
    last_fall = cyc;
    tick(H);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip, input bit bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ flip);
    ps2_bit(!bad_stop);
    PS2_DATA = 1'b1;
    tick(2 * H);
  endtask

  // Reference model: keyboard protocol semantics at the byte level.
  task automatic model_frame(input logic [7:0] b, input bit flip, input bit bad_stop);
    exp_t e;
    bit ok;
    logic [NK-1:0] nh;
    ok = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
    if (flip) ok = 0;
`endif
    e.is_err = 0; e.data = b; e.brk = 0; e.ext = 0;
    e.held = '0; e.press = '0; e.rel = '0; e.tmin = 0; e.tmax = 0;
    if (!ok) begin
      e.is_err = 1;
      sb.push_back(e);
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      nh = m_held;
      for (int i = 0; i < NK; i++)
        if (m_code[i] == b && m_kext[i] == m_ext) nh[i] = !m_brk;
      e.brk   = m_brk;
      e.ext   = m_ext;
      e.held  = nh;
      e.press = nh & ~m_held;
      e.rel   = m_held & ~nh;
      m_held  = nh;
      m_ext   = 0;
      m_brk   = 0;
      sb.push_back(e);
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit flip, input bit bad_stop);
    model_frame(b, flip, bad_stop);
    send_frame(b, flip, bad_stop);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_held"}, keys_held, 0);
    chk({tag, "_press"}, keys_press, 0);
    chk({tag, "_release"}, keys_release, 0);
    chk({tag, "_code_valid"}, code_valid, 0);
    chk({tag, "_code_data"}, code_data, 0);
    chk({tag, "_break_ext"}, {code_break, code_ext}, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (code_valid || frame_err)) begin
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_strobe: code_valid=%b frame_err=%b data=%h expected none",
                   code_valid, frame_err, code_data);
        end else begin
          e = sb.pop_front();
          if (e.is_err) begin
            chk("err_frame_err", frame_err, 1);
            chk("err_no_valid", code_valid, 0);
            if (e.tmax != 0) begin
              n_chk++;
              if (cyc < e.tmin || cyc > e.tmax) begin
                n_err++;
                $display("FAIL timeout_time: got cycle %0d expected %0d..%0d", cyc, e.tmin, e.tmax);
              end
            end
          end else begin
            chk("code_valid", code_valid, 1);
            chk("no_err_on_code", frame_err, 0);
            chk("code_data", code_data, e.data);
            chk("code_break", code_break, e.brk);
            chk("code_ext", code_ext, e.ext);
            chk("keys_held", keys_held, e.held);
            chk("keys_press", keys_press, e.press);
            chk("keys_release", keys_release, e.rel);
          end
        end
      end else if (rst_n && (keys_press != 0 || keys_release != 0)) begin
        n_chk++; n_err++;
        $display("FAIL stray_key_pulse: press=%b release=%b expected 0", keys_press, keys_release);
      end
    end
  end

  initial begin
    exp_t t;
    int w;
    int r;
    logic [7:0] pool[10] = '{8'h1C, 8'h1B, 8'h23, 8'h1D, 8'h75, 8'hE0, 8'hF0, 8'hE0, 8'h00, 8'hF0};
    logic [7:0] b;
    PS2_CLK = 1; PS2_DATA = 1; rst_n = 0;
    tick(3);
    chk_zero("reset");
    rst_n = 1;
    tick(5);

    // make/break of key 0 (and its duplicate, key 5)
    xfer(8'h1C, 0, 0); xfer(8'hF0, 0, 0); xfer(8'h1C, 0, 0);
    // typematic repeats
    xfer(8'h1D, 0, 0); xfer(8'h1D, 0, 0); xfer(8'h1D, 0, 0);
    xfer(8'hF0, 0, 0); xfer(8'h1D, 0, 0);
    // extended key versus the plain code of the same value
    xfer(8'hE0, 0, 0); xfer(8'h75, 0, 0); xfer(8'h75, 0, 0);
    xfer(8'hE0, 0, 0); xfer(8'hF0, 0, 0); xfer(8'h75, 0, 0);
    // flipped parity, then a clean 23 so key 2 ends up held either way
    xfer(8'h23, 1, 0); xfer(8'h23, 0, 0);
    // dropped frame keeps the pending E0
    xfer(8'hE0, 0, 0); xfer(8'h1C, 0, 1); xfer(8'h1B, 0, 0);

    // reset in the middle of a frame
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    rst_n = 0; PS2_CLK = 1; PS2_DATA = 1;
    tick(4);
    chk_zero("midreset");
    chk("sb_empty_at_reset", sb.size(), 0);
    m_held = '0; m_ext = 0; m_brk = 0;
    rst_n = 1;
    tick(4);
    xfer(8'h23, 0, 0);

    // watchdog: pending break survives the timeout
    xfer(8'h1B, 0, 0); xfer(8'hF0, 0, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    t.is_err = 1; t.data = 0; t.brk = 0; t.ext = 0;
    t.held = '0; t.press = '0; t.rel = '0;
    t.tmin = last_fall + TO + 1; t.tmax = last_fall + TO + 5;
    sb.push_back(t);
    tick(TO + 20);
    PS2_DATA = 1;
    xfer(8'h1B, 0, 0);

    // random traffic
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      b = (r == 8) ? 8'($urandom_range(0, 255)) : pool[r];
      xfer(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    w = 0;
    while (sb.size() != 0 && w < 500) begin
      tick(1);
      w++;
    end
    chk("sb_drained", sb.size(), 0);
    chk("final_held", keys_held, m_held);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
